// File: rtl/mpuf_pkg.sv
// Shared types and constants for the MPUF challenge/response sequencer.
package mpuf_pkg;

   // Width of the challenge and of the obfuscated challenge
   localparam int unsigned CHAL_W = 3;

   // Default timing parameters
   localparam int unsigned CLEAR_CYCLES_DEF  = 2;
   localparam int unsigned SETTLE_CYCLES_DEF = 8;
   localparam int unsigned NUM_SAMPLES_DEF   = 5;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StSettle,
      StSample,
      StDone
   } state_e;

   // Largest of three phase lengths; sizes the shared phase counter
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/mpuf_vote_acc.sv
// Per-bit ones counting, majority vote and stability tracking of sampled C_bar.
module mpuf_vote_acc
   import mpuf_pkg::*;
#(
   parameter int unsigned NUM_SAMPLES = NUM_SAMPLES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              acc_clear,
   input  logic              enable,
   input  logic [CHAL_W-1:0] sample,
   output logic [CHAL_W-1:0] cbar,
   output logic              stable
);

   localparam int unsigned   CW   = $clog2(NUM_SAMPLES + 1);
   localparam logic [CW-1:0] HALF = CW'(NUM_SAMPLES / 2);

   logic [CHAL_W-1:0][CW-1:0] ones_q;
   logic [CHAL_W-1:0]         first_q;
   logic                      have_first_q;
   logic                      stable_q;

   // Accumulate ones per bit; stability compares each sample with the first one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_q       <= '0;
         first_q      <= '0;
         have_first_q <= 1'b0;
         stable_q     <= 1'b0;
      end else if (acc_clear) begin
         ones_q       <= '0;
         first_q      <= '0;
         have_first_q <= 1'b0;
         stable_q     <= 1'b0;
      end else if (enable) begin
         for (int i = 0; i < CHAL_W; i++) begin
            ones_q[i] <= ones_q[i] + CW'(sample[i]);
         end
         if (!have_first_q) begin
            first_q      <= sample;
            have_first_q <= 1'b1;
            stable_q     <= 1'b1;
         end else if (sample != first_q) begin
            stable_q <= 1'b0;
         end
      end
   end

   // Majority decided from registered counts only, so no path from sample to cbar
   always_comb begin
      cbar = '0;
      for (int i = 0; i < CHAL_W; i++) begin
         cbar[i] = (ones_q[i] > HALF);
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/mpuf_crp_sequencer.sv
// Sequencer for one CRP evaluation: clear the PUF pair, let it settle, sample
// the obfuscated challenge several times and hand back a majority-voted result.
module mpuf_crp_sequencer
   import mpuf_pkg::*;
#(
   parameter int unsigned CLEAR_CYCLES  = CLEAR_CYCLES_DEF,
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int unsigned NUM_SAMPLES   = NUM_SAMPLES_DEF
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              req_valid,
   input  logic [CHAL_W-1:0] req_chal,
   output logic              req_ready,
   output logic              puf_clear,
   output logic [CHAL_W-1:0] puf_chal,
   input  logic [CHAL_W-1:0] puf_cbar,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [CHAL_W-1:0] resp_cbar,
   output logic              resp_stable,
   output logic              busy
);

   if (NUM_SAMPLES < 1 || (NUM_SAMPLES % 2) == 0) begin : g_bad_num_samples
      $error("NUM_SAMPLES must be odd and at least 1");
   end
   if (CLEAR_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_phase_len
      $error("CLEAR_CYCLES and SETTLE_CYCLES must be at least 1");
   end

   localparam int unsigned      MAX_PHASE  = max3(CLEAR_CYCLES, SETTLE_CYCLES, NUM_SAMPLES);
   localparam int unsigned      CNT_W      = $clog2(MAX_PHASE + 1);
   localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETL_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SMPL_LAST  = CNT_W'(NUM_SAMPLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;

   assign accept = (state_q == StIdle) && req_valid && req_ready;

   // Main FSM; all outputs except the vote result are registered here
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         puf_clear  <= 1'b1;
         puf_chal   <= '0;
         req_ready  <= 1'b0;
         busy       <= 1'b0;
         resp_valid <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               puf_clear <= 1'b0;
               if (accept) begin
                  puf_chal  <= req_chal;
                  puf_clear <= 1'b1;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= StClr;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            StClr: begin
               if (cnt_q == CLR_LAST) begin
                  cnt_q     <= '0;
                  puf_clear <= 1'b0;
                  state_q   <= StSettle;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            StSettle: begin
               if (cnt_q == SETL_LAST) begin
                  cnt_q   <= '0;
                  state_q <= StSample;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            StSample: begin
               if (cnt_q == SMPL_LAST) begin
                  cnt_q      <= '0;
                  resp_valid <= 1'b1;
                  state_q    <= StDone;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            StDone: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  req_ready  <= 1'b1;
                  state_q    <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Counters restart on accept, so each evaluation votes only over its own samples
   mpuf_vote_acc #(
      .NUM_SAMPLES(NUM_SAMPLES)
   ) u_vote_acc (
      .clk      (clk),
      .rst_n    (clear),
      .acc_clear(accept),
      .enable   (state_q == StSample),
      .sample   (puf_cbar),
      .cbar     (resp_cbar),
      .stable   (resp_stable)
   );

endmodule
